// File: rtl/fp_unit_arbiter_pkg.sv
// Shared constants for the fpUnit arbiter: opcodes, FSM states and a
// legality helper for incoming opcodes.
package fp_pkg;

  localparam logic [2:0] FSUBS   = 3'd0;
  localparam logic [2:0] FADDS   = 3'd1;
  localparam logic [2:0] FDIVS   = 3'd2;
  localparam logic [2:0] FMULS   = 3'd3;
  localparam logic [2:0] FIXSI   = 3'd4;
  localparam logic [2:0] FLOATIS = 3'd5;

  localparam logic [31:0] TWO_PI = 32'h40C90FDB;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } arb_state_t;

  // Opcodes 6 and 7 have no fpUnit operation behind them.
  function automatic logic op_is_legal(input logic [2:0] op);
    return op <= FLOATIS;
  endfunction

endpackage

// File: rtl/fp_unit_arbiter_if.sv
// Bundles the requester-facing bus and the fpUnit control pins of the arbiter.
// master = the arbiter itself, slave = requesters plus the fpUnit core.
interface fp_unit_arbiter_if #(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]    req;
  logic [32*N_REQ-1:0] req_dataa;
  logic [32*N_REQ-1:0] req_datab;
  logic [3*N_REQ-1:0]  req_op;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    ack;
  logic [31:0]         result;
  logic                err;
  logic                busy;

  logic [31:0]         fp_dataa;
  logic [31:0]         fp_datab;
  logic [2:0]          fp_operation;
  logic                fp_clk_en;
  logic                fp_done;
  logic [31:0]         fp_result;

  modport master (
    input  req, req_dataa, req_datab, req_op, fp_done, fp_result,
    output gnt, ack, result, err, busy,
           fp_dataa, fp_datab, fp_operation, fp_clk_en
  );

  modport slave (
    output req, req_dataa, req_datab, req_op, fp_done, fp_result,
    input  gnt, ack, result, err, busy,
           fp_dataa, fp_datab, fp_operation, fp_clk_en
  );

endinterface

// File: rtl/fp_unit_arbiter_rr_pick.sv
// Combinational round-robin picker: first unmasked request at or above ptr,
// wrapping modulo N.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         mask,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         winner,
  output logic                 valid
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!valid && req[idx] && !mask[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_unit_arbiter.sv
// Round-robin arbiter sharing one fpUnit core among N_REQ requesters; owns
// every fpUnit control pin and enforces the clk_en low gap between operations.
module fp_unit_arbiter
  import fp_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input logic               clk,
  input logic               rst,
  fp_unit_arbiter_if.master bus
);

  localparam int PW = $clog2(N_REQ);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  arb_state_t state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             err_q, err_d;
  logic [31:0]      result_q, result_d;
  logic [31:0]      dataa_q, dataa_d;
  logic [31:0]      datab_q, datab_d;
  logic [2:0]       op_q, op_d;
  logic             clk_en_q, clk_en_d;

  logic [N_REQ-1:0] pick_mask;
  logic [N_REQ-1:0] winner;
  logic             pick_valid;
  logic [PW-1:0]    win_idx;
  logic [31:0]      sel_a, sel_b;
  logic [2:0]       sel_op;

  // The requester being acked in RESP must not win again straight away.
  assign pick_mask = (state_q == RESP) ? gnt_q : '0;

  rr_pick #(.N(N_REQ)) u_pick (
    .req    (bus.req),
    .mask   (pick_mask),
    .ptr    (ptr_q),
    .winner (winner),
    .valid  (pick_valid)
  );

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_op  = '0;
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner[i]) begin
        sel_a   = bus.req_dataa[32*i +: 32];
        sel_b   = bus.req_datab[32*i +: 32];
        sel_op  = bus.req_op[3*i +: 3];
        win_idx = PW'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    ack_d    = '0;
    err_d    = 1'b0;
    result_d = result_q;
    dataa_d  = dataa_q;
    datab_d  = datab_q;
    op_d     = op_q;
    clk_en_d = clk_en_q;
    unique case (state_q)
      IDLE, RESP: begin
        state_d  = IDLE;
        gnt_d    = '0;
        clk_en_d = 1'b0;
        if (pick_valid) begin
          gnt_d   = winner;
          ptr_d   = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
          dataa_d = sel_a;
          datab_d = sel_b;
          op_d    = sel_op;
          cnt_d   = '0;
          // Illegal opcodes never reach the core: answer with err immediately.
          if (op_is_legal(sel_op)) begin
            state_d  = BUSY;
            clk_en_d = 1'b1;
          end else begin
            state_d = RESP;
            ack_d   = winner;
            err_d   = 1'b1;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 8'd1;
        if (bus.fp_done) begin
          result_d = bus.fp_result;
          clk_en_d = 1'b0;
          ack_d    = gnt_q;
          state_d  = RESP;
        end else if (cnt_q == TO_LAST) begin
          clk_en_d = 1'b0;
          ack_d    = gnt_q;
          err_d    = 1'b1;
          state_d  = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
      dataa_q  <= '0;
      datab_q  <= '0;
      op_q     <= '0;
      clk_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      result_q <= result_d;
      dataa_q  <= dataa_d;
      datab_q  <= datab_d;
      op_q     <= op_d;
      clk_en_q <= clk_en_d;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.ack          = ack_q;
  assign bus.err          = err_q;
  assign bus.result       = result_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.fp_dataa     = dataa_q;
  assign bus.fp_datab     = datab_q;
  assign bus.fp_operation = op_q;
  assign bus.fp_clk_en    = clk_en_q;

endmodule
